// File: rtl/channel_scheduler4.sv
// channel_scheduler4: merges four sample streams onto one valid/ready stream.
// Each requester has a one-entry holding register. A registered output stage
// is fed by a round-robin arbiter. Overrun flags are sticky and record samples
// dropped because a holding register was already full.
module channel_scheduler4 #(
   parameter int width = 32
) (
   input  logic             clk_in,
   input  logic             reset_n,
   input  logic [width-1:0] in_data_1,
   input  logic [width-1:0] in_data_2,
   input  logic [width-1:0] in_data_3,
   input  logic [width-1:0] in_data_4,
   input  logic [1:0]       in_error_1,
   input  logic [1:0]       in_error_2,
   input  logic [1:0]       in_error_3,
   input  logic [1:0]       in_error_4,
   input  logic             in_valid_1,
   input  logic             in_valid_2,
   input  logic             in_valid_3,
   input  logic             in_valid_4,
   output logic             in_ready_1,
   output logic             in_ready_2,
   output logic             in_ready_3,
   output logic             in_ready_4,
   input  logic [3:0]       chan_enable,
   input  logic             overrun_clear,
   output logic [width-1:0] out_data,
   output logic [1:0]       out_error,
   output logic [1:0]       out_channel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       overrun_flags
);

   logic [width-1:0] w_in_data [4];
   logic [1:0]       w_in_error [4];
   logic [3:0]       w_in_valid;
   logic [3:0]       w_ready;
   logic [3:0]       w_cand;
   logic [3:0]       w_ovr_set;
   logic             w_stage_free;
   logic             w_grant_valid;
   logic [1:0]       w_grant_idx;
   logic             w_do_grant;

   logic [width-1:0] r_hold_data [4];
   logic [1:0]       r_hold_err [4];
   logic [3:0]       r_full;
   logic [width-1:0] r_out_data;
   logic [1:0]       r_out_err;
   logic [1:0]       r_out_chan;
   logic             r_out_valid;
   logic [1:0]       r_last_grant;
   logic [3:0]       r_ovr;

   // Gather the per-requester ports into indexable arrays.
   always_comb begin
      w_in_data[0]  = in_data_1;
      w_in_data[1]  = in_data_2;
      w_in_data[2]  = in_data_3;
      w_in_data[3]  = in_data_4;
      w_in_error[0] = in_error_1;
      w_in_error[1] = in_error_2;
      w_in_error[2] = in_error_3;
      w_in_error[3] = in_error_4;
      w_in_valid    = {in_valid_4, in_valid_3, in_valid_2, in_valid_1};
   end

   // Ready depends only on registered fullness and the enable mask; a disabled channel always accepts (and discards).
   always_comb begin
      w_ready    = ~(r_full & chan_enable);
      in_ready_1 = w_ready[0];
      in_ready_2 = w_ready[1];
      in_ready_3 = w_ready[2];
      in_ready_4 = w_ready[3];
      w_ovr_set  = chan_enable & w_in_valid & r_full;
   end

   // Round-robin search from last_grant+1; iterating downward lets the nearest candidate win.
   always_comb begin
      w_cand        = r_full & chan_enable;
      w_stage_free  = ~r_out_valid | out_ready;
      w_grant_valid = 1'b0;
      w_grant_idx   = 2'd0;
      for (int k = 4; k >= 1; k--) begin
         if (w_cand[r_last_grant + 2'(k)]) begin
            w_grant_valid = 1'b1;
            w_grant_idx   = r_last_grant + 2'(k);
         end
      end
      w_do_grant = w_stage_free & w_grant_valid;
   end

   // Holding registers: flush when disabled, empty on grant, otherwise capture when empty.
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         r_full <= 4'd0;
         for (int n = 0; n < 4; n++) begin
            r_hold_data[n] <= '0;
            r_hold_err[n]  <= 2'd0;
         end
      end else begin
         for (int n = 0; n < 4; n++) begin
            if (!chan_enable[n]) begin
               r_full[n] <= 1'b0;
            end else if (w_do_grant && (w_grant_idx == 2'(n))) begin
               r_full[n] <= 1'b0;
            end else if (w_in_valid[n] && !r_full[n]) begin
               r_full[n]      <= 1'b1;
               r_hold_data[n] <= w_in_data[n];
               r_hold_err[n]  <= w_in_error[n];
            end
         end
      end
   end

   // Sticky overrun flags; a clear in the same cycle as a new overrun wins.
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         r_ovr <= 4'd0;
      end else if (overrun_clear) begin
         r_ovr <= 4'd0;
      end else begin
         r_ovr <= r_ovr | w_ovr_set;
      end
   end

   // Output stage: load the granted sample when free, drain to empty when nothing is pending, hold while stalled.
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         r_out_data   <= '0;
         r_out_err    <= 2'd0;
         r_out_chan   <= 2'd0;
         r_out_valid  <= 1'b0;
         r_last_grant <= 2'd3;
      end else if (w_stage_free) begin
         if (w_grant_valid) begin
            r_out_data   <= r_hold_data[w_grant_idx];
            r_out_err    <= r_hold_err[w_grant_idx];
            r_out_chan   <= w_grant_idx;
            r_out_valid  <= 1'b1;
            r_last_grant <= w_grant_idx;
         end else begin
            r_out_valid  <= 1'b0;
         end
      end
   end

   assign out_data      = r_out_data;
   assign out_error     = r_out_err;
   assign out_channel   = r_out_chan;
   assign out_valid     = r_out_valid;
   assign overrun_flags = r_ovr;

endmodule

// File: tb/tb_channel_scheduler4.sv
// Testbench for channel_scheduler4: directed scenarios plus randomized traffic,
// all compared against a queue-free behavioural model of the scheduler rules.
module tb_channel_scheduler4;

   localparam int W = 32;

   logic          clk_in = 1'b0;
   logic          reset_n;
   logic [W-1:0]  inData [4];
   logic [1:0]    inErr [4];
   logic [3:0]    inValid;
   logic [3:0]    chanEnable;
   logic          overrunClear;
   logic          outReady;
   logic [W-1:0]  outData;
   logic [1:0]    outError;
   logic [1:0]    outChannel;
   logic          outValid;
   logic [3:0]    overrunFlags;
   logic          inReady1, inReady2, inReady3, inReady4;
   logic [3:0]    inReady;

   assign inReady = {inReady4, inReady3, inReady2, inReady1};

   // Model state: per-channel buffered sample and the registered output.
   bit            mFull [4];
   logic [W-1:0]  mData [4];
   logic [1:0]    mErr [4];
   bit            mOutValid;
   logic [W-1:0]  mOutData;
   logic [1:0]    mOutErr;
   int            mOutChan;
   int            mLast;
   logic [3:0]    mOvr;

   int nChecks = 0;
   int nFail = 0;

   channel_scheduler4 #(.width(W)) dut (
      .clk_in(clk_in), .reset_n(reset_n),
      .in_data_1(inData[0]), .in_data_2(inData[1]), .in_data_3(inData[2]), .in_data_4(inData[3]),
      .in_error_1(inErr[0]), .in_error_2(inErr[1]), .in_error_3(inErr[2]), .in_error_4(inErr[3]),
      .in_valid_1(inValid[0]), .in_valid_2(inValid[1]), .in_valid_3(inValid[2]), .in_valid_4(inValid[3]),
      .in_ready_1(inReady1), .in_ready_2(inReady2), .in_ready_3(inReady3), .in_ready_4(inReady4),
      .chan_enable(chanEnable), .overrun_clear(overrunClear),
      .out_data(outData), .out_error(outError), .out_channel(outChannel),
      .out_valid(outValid), .out_ready(outReady), .overrun_flags(overrunFlags)
   );

   always #5 clk_in = ~clk_in;

   // Safety net so the run can never hang.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired dut=running required=finished");
      $fatal(1, "[TB] watchdog");
   end

   task automatic modelReset();
      for (int c = 0; c < 4; c++) begin
         mFull[c] = 0;
         mData[c] = '0;
         mErr[c]  = 2'b00;
      end
      mOutValid = 0;
      mOutData  = '0;
      mOutErr   = 2'b00;
      mOutChan  = 0;
      mLast     = 3;
      mOvr      = 4'b0000;
   endtask

   // Advance the model by one clock using the currently driven inputs, then let the DUT take the same edge.
   task automatic step();
      bit free;
      int pick;
      free = !mOutValid || outReady;
      pick = -1;
      for (int k = 1; k <= 4; k++) begin
         int c;
         c = (mLast + k) % 4;
         if (pick < 0 && mFull[c] && chanEnable[c]) pick = c;
      end
      for (int c = 0; c < 4; c++) begin
         if (!chanEnable[c]) begin
            mFull[c] = 0;
         end else if (inValid[c]) begin
            if (mFull[c]) begin
               mOvr[c] = 1'b1;
            end else begin
               mFull[c] = 1;
               mData[c] = inData[c];
               mErr[c]  = inErr[c];
            end
         end
      end
      if (free) begin
         if (pick >= 0) begin
            mOutValid   = 1;
            mOutData    = mData[pick];
            mOutErr     = mErr[pick];
            mOutChan    = pick;
            mFull[pick] = 0;
            mLast       = pick;
         end else begin
            mOutValid = 0;
         end
      end
      if (overrunClear) mOvr = 4'b0000;
      @(posedge clk_in);
      #1;
   endtask

   function automatic logic [44:0] expVec();
      logic [3:0] rdy;
      for (int c = 0; c < 4; c++) rdy[c] = !(mFull[c] && chanEnable[c]);
      return {mOutValid, mOutValid ? 2'(mOutChan) : 2'b00, mOutValid ? mOutData : 32'h0,
              mOutValid ? mOutErr : 2'b00, mOvr, rdy};
   endfunction

   function automatic logic [44:0] dutVec();
      return {outValid, mOutValid ? outChannel : 2'b00, mOutValid ? outData : 32'h0,
              mOutValid ? outError : 2'b00, overrunFlags, inReady};
   endfunction

   task automatic idleInputs();
      inValid      = 4'b0000;
      overrunClear = 1'b0;
      for (int c = 0; c < 4; c++) begin
         inData[c] = $urandom();
         inErr[c]  = 2'($urandom_range(0, 3));
      end
   endtask

   task automatic doReset();
      idleInputs();
      reset_n = 1'b0;
      modelReset();
      @(posedge clk_in);
      #1;
      @(posedge clk_in);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      chanEnable = 4'b1111;
      outReady   = 1'b1;
      doReset();
      nChecks++;
      if (outValid !== 1'b0) begin nFail++; $display("[TB] FAIL reset_out_valid dut=%b required=0", outValid); end
      nChecks++;
      if (outData !== 32'h0) begin nFail++; $display("[TB] FAIL reset_out_data dut=%h required=0", outData); end
      nChecks++;
      if (outError !== 2'b00 || outChannel !== 2'b00) begin
         nFail++; $display("[TB] FAIL reset_err_chan dut=%b/%b required=00/00", outError, outChannel);
      end
      nChecks++;
      if (overrunFlags !== 4'b0000) begin nFail++; $display("[TB] FAIL reset_overrun dut=%b required=0000", overrunFlags); end
      nChecks++;
      if (inReady !== 4'b1111) begin nFail++; $display("[TB] FAIL reset_in_ready dut=%b required=1111", inReady); end
   endtask

   task automatic test_single_sample();
      doReset();
      outReady  = 1'b1;
      inData[2] = 32'h12345678;
      inErr[2]  = 2'b01;
      inValid   = 4'b0100;
      step();
      inValid = 4'b0000;
      nChecks++;
      if (inReady3 !== 1'b0 || outValid !== 1'b0) begin
         nFail++; $display("[TB] FAIL single_capture dut=rdy%b/v%b required=rdy0/v0", inReady3, outValid);
      end
      step();
      nChecks++;
      if ({outValid, outChannel, outData, outError, inReady3} !== {1'b1, 2'd2, 32'h12345678, 2'b01, 1'b1}) begin
         nFail++;
         $display("[TB] FAIL single_output dut=v%b ch%0d d%h e%b rdy%b required=v1 ch2 d12345678 e01 rdy1",
                  outValid, outChannel, outData, outError, inReady3);
      end
      step();
      nChecks++;
      if (outValid !== 1'b0) begin nFail++; $display("[TB] FAIL single_drain dut=%b required=0", outValid); end
   endtask

   task automatic test_round_robin();
      doReset();
      outReady = 1'b1;
      for (int rep = 0; rep < 2; rep++) begin
         for (int c = 0; c < 4; c++) inData[c] = $urandom();
         inValid = 4'b1111;
         step();
         inValid = 4'b0000;
         for (int g = 0; g < 4; g++) begin
            step();
            nChecks++;
            if (outValid !== 1'b1 || outChannel !== 2'(g) || dutVec() !== expVec()) begin
               nFail++;
               $display("[TB] FAIL round_robin rep%0d grant%0d dut=v%b ch%0d vec=%h required=v1 ch%0d vec=%h",
                        rep, g, outValid, outChannel, dutVec(), g, expVec());
            end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] held;
      doReset();
      outReady  = 1'b0;
      held      = $urandom();
      inData[0] = held;
      inValid   = 4'b0001;
      step();
      inValid = 4'b0000;
      step();
      for (int i = 0; i < 5; i++) begin
         if (i == 0) inValid = 4'b0100;
         step();
         inValid = 4'b0000;
         nChecks++;
         if (outValid !== 1'b1 || outChannel !== 2'd0 || outData !== held || dutVec() !== expVec()) begin
            nFail++;
            $display("[TB] FAIL backpressure_hold cyc%0d dut=v%b ch%0d d%h required=v1 ch0 d%h",
                     i, outValid, outChannel, outData, held);
         end
      end
      outReady = 1'b1;
      step();
      nChecks++;
      if (outValid !== 1'b1 || outChannel !== 2'd2 || dutVec() !== expVec()) begin
         nFail++; $display("[TB] FAIL backpressure_release dut=v%b ch%0d required=v1 ch2", outValid, outChannel);
      end
      step();
      nChecks++;
      if (outValid !== 1'b0) begin nFail++; $display("[TB] FAIL backpressure_drain dut=%b required=0", outValid); end
   endtask

   task automatic test_overrun();
      logic [W-1:0] orig;
      doReset();
      outReady = 1'b0;
      inValid  = 4'b0001;
      step();
      inValid = 4'b0000;
      step();
      orig      = $urandom();
      inData[3] = orig;
      inValid   = 4'b1000;
      step();
      nChecks++;
      if (inReady4 !== 1'b0 || overrunFlags !== 4'b0000) begin
         nFail++; $display("[TB] FAIL overrun_fill dut=rdy%b f%b required=rdy0 f0000", inReady4, overrunFlags);
      end
      inData[3] = 32'hAAAA0000;
      step();
      inValid = 4'b0000;
      nChecks++;
      if (overrunFlags !== 4'b1000) begin nFail++; $display("[TB] FAIL overrun_set dut=%b required=1000", overrunFlags); end
      overrunClear = 1'b1;
      step();
      nChecks++;
      if (overrunFlags !== 4'b0000) begin nFail++; $display("[TB] FAIL overrun_clear dut=%b required=0000", overrunFlags); end
      inData[3] = 32'hAAAA0000;
      inValid   = 4'b1000;
      step();
      inValid      = 4'b0000;
      overrunClear = 1'b0;
      nChecks++;
      if (overrunFlags !== 4'b0000) begin nFail++; $display("[TB] FAIL overrun_clear_wins dut=%b required=0000", overrunFlags); end
      outReady = 1'b1;
      step();
      nChecks++;
      if (outValid !== 1'b1 || outChannel !== 2'd3 || outData !== orig || dutVec() !== expVec()) begin
         nFail++; $display("[TB] FAIL overrun_original dut=v%b ch%0d d%h required=v1 ch3 d%h", outValid, outChannel, outData, orig);
      end
   endtask

   task automatic test_disable();
      doReset();
      chanEnable = 4'b1101;
      for (int i = 0; i < 40; i++) begin
         for (int c = 0; c < 4; c++) inData[c] = $urandom();
         inValid  = 4'($urandom_range(0, 15)) | 4'b0010;
         outReady = 1'($urandom_range(0, 1));
         step();
         nChecks++;
         if ((outValid && outChannel == 2'd1) || inReady2 !== 1'b1 || overrunFlags[1] !== 1'b0 || dutVec() !== expVec()) begin
            nFail++;
            $display("[TB] FAIL disable cyc%0d dut=ch%0d rdy2=%b ovr=%b vec=%h required=no ch1 rdy2=1 ovr1=0 vec=%h",
                     i, outChannel, inReady2, overrunFlags, dutVec(), expVec());
         end
      end
      inValid    = 4'b0000;
      chanEnable = 4'b1111;
   endtask

   task automatic test_random();
      doReset();
      for (int i = 0; i < 400; i++) begin
         for (int c = 0; c < 4; c++) begin
            inData[c] = $urandom();
            inErr[c]  = 2'($urandom_range(0, 3));
         end
         inValid      = 4'($urandom_range(0, 15));
         outReady     = ($urandom_range(0, 3) != 0);
         overrunClear = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 15) == 0) chanEnable = 4'($urandom_range(0, 15));
         step();
         nChecks++;
         if (dutVec() !== expVec()) begin
            nFail++; $display("[TB] FAIL random cyc%0d dut=%h required=%h", i, dutVec(), expVec());
         end
      end
      idleInputs();
      chanEnable = 4'b1111;
   endtask

   task automatic test_reset_mid();
      doReset();
      outReady = 1'b0;
      inValid  = 4'b0111;
      step();
      inValid = 4'b0000;
      step();
      inValid = 4'b0001;
      step();
      inValid = 4'b0000;
      #2;
      reset_n = 1'b0;
      modelReset();
      #1;
      nChecks++;
      if ({outValid, outData, outError, outChannel, overrunFlags} !== '0 || inReady !== 4'b1111) begin
         nFail++;
         $display("[TB] FAIL reset_mid dut=v%b d%h e%b ch%0d f%b rdy%b required=all zero rdy1111",
                  outValid, outData, outError, outChannel, overrunFlags, inReady);
      end
      @(posedge clk_in);
      #1;
      reset_n  = 1'b1;
      outReady = 1'b1;
      inValid  = 4'b1111;
      step();
      inValid = 4'b0000;
      step();
      nChecks++;
      if (outValid !== 1'b1 || outChannel !== 2'd0 || dutVec() !== expVec()) begin
         nFail++; $display("[TB] FAIL reset_mid_first_grant dut=v%b ch%0d required=v1 ch0", outValid, outChannel);
      end
   endtask

   initial begin
      reset_n      = 1'b0;
      chanEnable   = 4'b1111;
      outReady     = 1'b1;
      idleInputs();
      modelReset();
      test_reset();
      test_single_sample();
      test_round_robin();
      test_backpressure();
      test_overrun();
      test_disable();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
      $finish;
   end

endmodule
